// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic used by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, then summed LSB-first through
// one full adder, one bit per clock; the result is held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH:0]   w_psum_ext;
  logic [WIDTH-1:0] w_psum_next;

  full_adder u_full_adder (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c_in  (r_carry),
    .sum   (w_fa_sum),
    .c_out (w_fa_cout)
  );

  // Shifting through a WIDTH+1 vector keeps the MSB insert legal even when WIDTH is 1.
  assign w_psum_ext  = {w_fa_sum, r_psum};
  assign w_psum_next = w_psum_ext[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= c_in;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_psum  <= w_psum_next;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_psum_next;
            r_cout  <= w_fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 4 with a result scoreboard.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [8:0] q8[$];
  logic [8:0] last8;

  logic       start1, a1, b1, c1, busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] q1[$];

  logic       start4, c4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [4:0] q4[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
  );

  task automatic test_reset;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b c_out=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy1, done1, cout1, sum1, busy4, done4, cout4, sum4} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w1_w4: got w1 %b%b%b%b w4 %b%b%b%h, want all 0",
               busy1, done1, cout1, sum1, busy4, done4, cout4, sum4);
    end
  endtask

  // One 8-bit addition: checks latency, busy length, held result during RUN, result and pulse width.
  task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string tag);
    logic [8:0] exp;
    int lat;
    int busy_cnt;
    @(negedge clk);
    a8 = av; b8 = bv; c8 = cv; start8 = 1'b1;
    q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      checks++;
      if ({cout8, sum8} !== last8) begin
        errors++;
        $display("FAIL %s_hold: got %h during RUN, want previous %h", tag, {cout8, sum8}, last8);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || busy_cnt !== 8) begin
      errors++;
      $display("FAIL %s_latency: got done after %0d cycles busy %0d, want 8 and 8", tag, lat, busy_cnt);
    end
    if (done8) begin
      exp = q8.pop_front();
      last8 = exp;
      checks++;
      if ({cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL %s_result: got c_out=%b sum=%h, want c_out=%b sum=%h", tag, cout8, sum8, exp[8], exp[7:0]);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL %s_pulse: got done=%b busy=%b after DONE, want 0 0", tag, done8, busy8);
      end
    end
  endtask

  task automatic test_patterns;
    do_add8(8'h00, 8'h00, 1'b0, "zero");
    do_add8(8'hFF, 8'h01, 1'b0, "ff_01");
    do_add8(8'hA5, 8'h5A, 1'b1, "a5_5a_c");
    do_add8(8'h7F, 8'h01, 1'b0, "7f_01");
    do_add8(8'hC8, 8'h9B, 1'b1, "c8_9b_c");
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    int lat;
    int dones;
    @(negedge clk);
    a8 = 8'h9A; b8 = 8'h47; c8 = 1'b1; start8 = 1'b1;
    q8.push_back(9'h09A + 9'h047 + 9'd1);
    @(negedge clk);
    lat = 0; dones = 0;
    while (!done8 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); start8 = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, want 8", lat);
    end
    if (done8) begin
      dones++;
      exp = q8.pop_front();
      last8 = exp;
      checks++;
      if ({cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL b2b_result: got %h, want %h", {cout8, sum8}, exp);
      end
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_start: got busy=%b after start in DONE, want 0", busy8);
    end
    repeat (12) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d done pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; c8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h077);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b c_out=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    void'(q8.pop_back());
    last8 = 9'd0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles after abort, want 0", dones);
    end
    do_add8(8'h12, 8'h34, 1'b0, "after_abort");
  endtask

  task automatic test_width1;
    logic [1:0] exp;
    int lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = i[0]; b1 = i[1]; c1 = i[2]; start1 = 1'b1;
      q1.push_back({1'b0, i[0]} + {1'b0, i[1]} + {1'b0, i[2]});
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL w1_latency_%0d: got %0d cycles, want 1", i, lat);
      end
      if (done1) begin
        exp = q1.pop_front();
        checks++;
        if ({cout1, sum1} !== exp) begin
          errors++;
          $display("FAIL w1_result_%0d: got %b, want %b", i, {cout1, sum1}, exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep4;
    logic [4:0] exp;
    int lat;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = i[3:0]; b4 = i[7:4]; c4 = i[8]; start4 = 1'b1;
      q4.push_back({1'b0, a4} + {1'b0, b4} + {4'd0, c4});
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (!done4 || lat !== 4) begin
        errors++;
        $display("FAIL w4_timing_%0d: done=%b after %0d cycles, want done after 4", i, done4, lat);
      end
      if (done4) begin
        exp = q4.pop_front();
        checks++;
        if ({cout4, sum4} !== exp) begin
          errors++;
          $display("FAIL w4_result_%0d: got %h, want %h", i, {cout4, sum4}, exp);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
    last8 = 9'd0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_patterns;
    test_back_to_back;
    test_reset_abort;
    test_width1;
    test_sweep4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand, sum and shift-register width (legal range 1..32).
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-003 Port rst SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide, and requests a new addition; it is sampled only in IDLE.
REQ-005 Port a SHALL be an input, WIDTH bits wide, carrying operand A, captured on start.
REQ-006 Port b SHALL be an input, WIDTH bits wide, carrying operand B, captured on start.
REQ-007 Port c_in SHALL be an input, 1 bit wide, carrying the initial carry, captured on start.
REQ-008 Port busy SHALL be an output, 1 bit wide, high while the state is RUN.
REQ-009 Port done SHALL be an output, 1 bit wide, giving a one-cycle pulse when the result is valid.
REQ-010 Port sum SHALL be an output, WIDTH bits wide, carrying the registered result (A+B+c_in) mod 2^WIDTH.
REQ-011 Port c_out SHALL be an output, 1 bit wide, carrying the registered carry-out of the completed addition.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge (E0) SHALL load a_sr<=a, b_sr<=b, carry<=c_in and bit counter<=0, then enter RUN.
REQ-014 In RUN, each edge SHALL apply a_sr[0], b_sr[0] and carry to one full_adder instance.
REQ-015 At the same edge, the adder's sum bit SHALL shift into the MSB of the partial-sum register, a_sr and b_sr SHALL shift right, carry SHALL take the adder's c_out, and the counter SHALL increment.
REQ-016 Processing SHALL be LSB-first; the WIDTH-th RUN edge (E_WIDTH) SHALL load sum and c_out from the completed partial sum and carry, then enter DONE.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE, which begins WIDTH cycles after E0; the next edge SHALL return the FSM to IDLE.
REQ-018 sum and c_out SHALL hold their last result, unchanged during a subsequent RUN, until the next completion overwrites them.
REQ-019 start SHALL be ignored in RUN and in DONE, with no restart and no queuing.
REQ-020 Inputs a, b and c_in SHALL be don't-care except at the accepting edge E0.
REQ-021 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within one operation.
REQ-022 For WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-023 rst=1 SHALL immediately force the state to IDLE and clear busy, done, sum, c_out, carry, the counter and all shift registers to 0.
REQ-024 Asserting rst during RUN or DONE SHALL abort the operation with no done pulse; after rst deasserts, the first start SHALL be accepted normally.

Structure
REQ-025 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and DEFAULT_WIDTH=8 SHALL reside in a shared package/header, serial_adder_pkg.
REQ-026 The per-bit arithmetic SHALL use exactly one instance of the existing full_adder sub-module (ports a, b, c_in, sum, c_out); no other adder logic is permitted.
REQ-027 All outputs SHALL be registered.

Verification (WIDTH=8 unless noted)
REQ-028 Scenario: a=0x00, b=0x00, c_in=0, start -> done 8 cycles after E0, sum=0x00, c_out=0, busy high for exactly 8 cycles.
REQ-029 Scenario: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; then a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1; then a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0.
REQ-030 Scenario: start pulsed every cycle while busy -> exactly one done per accepted start, and operands changed mid-RUN do not alter the result.
REQ-031 Scenario: rst asserted on the 4th RUN cycle -> outputs read 0 immediately, no done pulse follows, and the next start with 0x12+0x34 -> sum=0x46.
REQ-032 Scenario: WIDTH=1 with a=1, b=1, c_in=1 -> sum=1, c_out=1, done 1 cycle after E0.
REQ-033 Scenario: exhaustive sweep at WIDTH=4 (512 combinations) -> every {c_out,sum} equals a+b+c_in.
